load_store_controller: RTL and testbench

LOAD_STORE_CONTROLLER -- requirements
Module: load_store_controller

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_controller.sv | 140 ++++++++++++++
 tb/tb_load_store_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store controller:
//   size_e          - request size encoding (byte / half / word / illegal)
//   state_e         - controller FSM states
//   is_bad_access() - true for an illegal size or a misaligned address
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // A half must sit on an even byte and a word on a 4-byte boundary.
    function automatic logic is_bad_access(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
// Purely combinational lane handling for the load/store controller.
//   word       in   32  memory word captured during READ
//   addr_lo    in    2  byte offset within the word
//   size       in    2  request size (lsu_pkg::size_e encoding)
//   is_unsigned in   1  zero-extend (1) / sign-extend (0) sub-word loads
//   wdata      in   32  right-aligned store data
//   load_data  out  32  selected lane, extended to 32 bits
//   store_data out  32  word to write: whole wdata for word stores,
//                       otherwise the captured word with one lane replaced
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    always_comb begin
        byte_sel   = word[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
        sign_bit   = 1'b0;
        load_data  = word;
        store_data = wdata;

        case (size)
            SIZE_BYTE: begin
                sign_bit  = ~is_unsigned & byte_sel[7];
                load_data = {{24{sign_bit}}, byte_sel};
                store_data = word;
                store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                sign_bit  = ~is_unsigned & half_sel[15];
                load_data = {{16{sign_bit}}, half_sel};
                store_data = word;
                if (addr_lo[1]) begin
                    store_data[31:16] = wdata[15:0];
                end else begin
                    store_data[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data  = word;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_controller.sv
// load_store_controller
// Bridges single core load/store requests (byte/half/word, any byte address)
// onto a word-only data memory. Sub-word stores are done as read-modify-write.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (accepted when both high)
//   req_write/req_size/req_unsigned/req_addr/req_wdata   request fields
//   resp_valid               one-cycle completion pulse
//   resp_rdata/resp_error    extended load data / misaligned-or-illegal flag
//   mem_address/mem_write_data/mem_write/mem_read/mem_read_data
//                            word-memory port (read data changes on the
//                            falling edge inside READ)
module load_store_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    state_e      state;
    state_e      state_next;

    logic [31:0] addr_q;
    size_e       size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;

    logic        accept;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign accept = (state == IDLE) && req_valid;

    // Word index field spelled out separately from the bits above it;
    // the bus address is the latched byte address with the lane bits cleared.
    assign mem_address    = {addr_q[31:ADDR_WIDTH+2], addr_q[ADDR_WIDTH+1:2], 2'b00};
    assign mem_write_data = store_data;

    lsu_lane_align u_lane_align (
        .word        (word_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= SIZE_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            word_q     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= size_e'(req_size);
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                err_q      <= is_bad_access(req_size, req_addr[1:0]);
            end
            // Memory output settled on the falling edge inside READ.
            if (state == READ) begin
                word_q <= mem_read_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = '0;

        case (state)
            IDLE: begin
                req_ready = ~rst;
                if (req_valid) begin
                    if (is_bad_access(req_size, req_addr[1:0])) begin
                        state_next = RESP;
                    end else if (!req_write) begin
                        state_next = READ;
                    end else if (req_size == SIZE_WORD) begin
                        state_next = WRITE;
                    end else begin
                        // Sub-word store: fetch the word first, then merge.
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_read   = 1'b1;
                state_next = write_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_write  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                if (!err_q && !write_q) begin
                    resp_rdata = load_data;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_controller.sv
// tb_load_store_controller
// Self-checking bench: word memory model on the memory port, a byte-level
// reference model of the request semantics, directed and random scenarios.
module tb_load_store_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_controller #(.ADDR_WIDTH(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // Attached word memory: output changes on the falling edge during a read.
    logic [31:0] mem [0:1023];
    always @(negedge clk) if (mem_read) mem_read_data <= mem[mem_address[11:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[11:2]] <= mem_write_data;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;
    always @(posedge clk) begin
        if (mem_read)   rd_cnt   <= rd_cnt + 1;
        if (mem_write)  wr_cnt   <= wr_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // Reference: memory viewed as bytes, loads/stores done lane by lane.
    logic [31:0] ref_mem [0:1023];

    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] e_rdata, output logic e_err,
                         output int e_lat, output int e_rd, output int e_wr);
        int n, lane, w;
        longint val;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lane = int'(addr % 4);
        w    = int'((addr / 4) % 1024);
        e_err = (sz == 2'd3) || ((lane % n) != 0);
        e_rdata = 32'h0; e_rd = 0; e_wr = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!wr) begin
            val = 0;
            for (int i = 0; i < n; i++)
                val += longint'((ref_mem[w] >> (8 * (lane + i))) & 32'hFF) << (8 * i);
            if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                val -= longint'(1) << (8 * n);
            e_rdata = val[31:0];
            e_lat = 2; e_rd = 1;
        end else begin
            for (int i = 0; i < n; i++)
                ref_mem[w] = (ref_mem[w] & ~(32'hFF << (8 * (lane + i))))
                           | (((wd >> (8 * i)) & 32'hFF) << (8 * (lane + i)));
            e_wr = 1;
            e_rd  = (n == 4) ? 0 : 1;
            e_lat = (n == 4) ? 2 : 3;
        end
    endtask

    // Drives one request from IDLE and collects what the DUT did.
    // Called and returns at #1 after a rising edge; lat=0 means no response.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int nrd, output int nwr, output logic single);
        int rd0, wr0;
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 32'h0; err = 1'b0; single = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_error;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            single = !resp_valid;
        end
        @(posedge clk);
        #1;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h44; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error: got %b expected 0", resp_error); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b expected 00", {mem_read, mem_write}); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_store_load();
        int lat, nrd, nwr, x_lat, x_rd, x_wr;
        logic [31:0] rd, x_rdata;
        logic er, sg, x_err;
        model(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr, sg);
        checks++; if (lat != x_lat) begin errors++; $display("FAIL word_store_latency: got %0d expected %0d", lat, x_lat); end
        checks++; if ({nrd, nwr} != {x_rd, x_wr}) begin errors++; $display("FAIL word_store_accesses: got rd=%0d wr=%0d expected rd=%0d wr=%0d", nrd, nwr, x_rd, x_wr); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL word_store_resp: got rdata=%h err=%b expected 0/0", rd, er); end
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_rdata: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_error: got %b expected 0", er); end
        checks++; if (lat != 2) begin errors++; $display("FAIL word_load_latency: got %0d expected 2", lat); end
        checks++; if (sg !== 1'b1) begin errors++; $display("FAIL word_load_single_pulse: got %b expected 1", sg); end
    endtask

    task automatic test_signed_byte_load();
        int lat, nrd, nwr, x_lat, x_rd, x_wr;
        logic [31:0] rd, x_rdata;
        logic er, sg, x_err;
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, lat, rd, er, nrd, nwr, sg);
        do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed: got %h expected ffffff80", rd); end
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned: got %h expected 00000080", rd); end
        model(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== x_rdata) begin errors++; $display("FAIL half_load_signed: got %h expected %h", rd, x_rdata); end
        model(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== x_rdata) begin errors++; $display("FAIL byte_load_lane1: got %h expected %h", rd, x_rdata); end
    endtask

    task automatic test_half_rmw();
        int lat, nrd, nwr, x_lat, x_rd, x_wr;
        logic [31:0] rd, x_rdata;
        logic er, sg, x_err;
        model(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, lat, rd, er, nrd, nwr, sg);
        model(1'b1, 2'd1, 1'b0, 32'h32, 32'h5555AAAA, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'h5555AAAA, lat, rd, er, nrd, nwr, sg);
        checks++; if (lat != 3) begin errors++; $display("FAIL half_rmw_latency: got %0d expected 3", lat); end
        checks++; if (nrd != 1 || nwr != 1) begin errors++; $display("FAIL half_rmw_accesses: got rd=%0d wr=%0d expected rd=1 wr=1", nrd, nwr); end
        checks++; if (mem[12] !== 32'hAAAA3344) begin errors++; $display("FAIL half_rmw_memory: got %h expected aaaa3344", mem[12]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== ref_mem[12]) begin errors++; $display("FAIL half_rmw_readback: got %h expected %h", rd, ref_mem[12]); end
    endtask

    task automatic test_misaligned();
        int lat, nrd, nwr;
        logic [31:0] rd;
        logic er, sg;
        do_req(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (lat != 1) begin errors++; $display("FAIL misaligned_latency: got %0d expected 1", lat); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_error: got %b expected 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_rdata: got %h expected 0", rd); end
        checks++; if (nrd != 0 || nwr != 0) begin errors++; $display("FAIL misaligned_accesses: got rd=%0d wr=%0d expected 0/0", nrd, nwr); end
        do_req(1'b1, 2'd1, 1'b0, 32'h33, 32'h1234, lat, rd, er, nrd, nwr, sg);
        checks++; if (er !== 1'b1 || nwr != 0 || lat != 1) begin errors++; $display("FAIL misaligned_half_store: got err=%b wr=%0d lat=%0d expected 1/0/1", er, nwr, lat); end
        do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'h1234, lat, rd, er, nrd, nwr, sg);
        checks++; if (er !== 1'b1 || nwr != 0 || nrd != 0) begin errors++; $display("FAIL illegal_size: got err=%b rd=%0d wr=%0d expected 1/0/0", er, nrd, nwr); end
    endtask

    task automatic test_reset_mid_op();
        int lat, nrd, nwr, x_lat, x_rd, x_wr, r0, w0;
        logic [31:0] rd, x_rdata;
        logic er, sg, x_err;
        model(1'b1, 2'd2, 1'b0, 32'h50, 32'h12345678, x_rdata, x_err, x_lat, x_rd, x_wr);
        do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h12345678, lat, rd, er, nrd, nwr, sg);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h50; req_wdata = 32'hAB;
        @(negedge clk);
        r0 = resp_cnt; w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_in_read: got %b expected 1", mem_read); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got resp=%b wr=%b expected 0/0", resp_valid, mem_write); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_after: got %b expected 1", req_ready); end
        @(posedge clk);
        #1;
        checks++; if (resp_cnt != r0 || wr_cnt != w0) begin errors++; $display("FAIL rst_mid_no_activity: got resp=%0d wr=%0d expected 0/0", resp_cnt - r0, wr_cnt - w0); end
        do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, lat, rd, er, nrd, nwr, sg);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rst_mid_memory: got %h expected 12345678", rd); end
    endtask

    task automatic test_random();
        int lat, nrd, nwr, x_lat, x_rd, x_wr;
        logic [31:0] rd, x_rdata, a, d;
        logic er, sg, x_err, w, u;
        logic [1:0] s;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), d, x_rdata, x_err, x_lat, x_rd, x_wr);
            do_req(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), d, lat, rd, er, nrd, nwr, sg);
        end
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1)); s = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1)); a = 32'h100 + $urandom_range(0, 63);
            d = $urandom;
            model(w, s, u, a, d, x_rdata, x_err, x_lat, x_rd, x_wr);
            do_req(w, s, u, a, d, lat, rd, er, nrd, nwr, sg);
            checks++; if (rd !== x_rdata || er !== x_err) begin errors++; $display("FAIL rand_resp[%0d]: got rdata=%h err=%b expected rdata=%h err=%b", i, rd, er, x_rdata, x_err); end
            checks++; if (lat != x_lat || !sg) begin errors++; $display("FAIL rand_latency[%0d]: got %0d single=%b expected %0d single=1", i, lat, sg, x_lat); end
            checks++; if (nrd != x_rd || nwr != x_wr) begin errors++; $display("FAIL rand_accesses[%0d]: got rd=%0d wr=%0d expected rd=%0d wr=%0d", i, nrd, nwr, x_rd, x_wr); end
        end
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 2'd2, 1'b0, 32'h100 + 32'(4 * i), 32'h0, lat, rd, er, nrd, nwr, sg);
            checks++; if (rd !== ref_mem[64 + i]) begin errors++; $display("FAIL rand_sweep[%0d]: got %h expected %h", i, rd, ref_mem[64 + i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q_rdata [$];
        logic        q_err [$];
        logic [31:0] x_rdata, exp_d;
        logic        x_err, exp_e, prev_resp, acc;
        int          x_lat, x_rd, x_wr, sent, nresp, last_acc, prev_lat, r0;
        int          ops = 10;
        sent = 0; nresp = 0; last_acc = 0; prev_lat = 0; prev_resp = 1'b0;
        r0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1)); req_addr = 32'h100 + $urandom_range(0, 63); req_wdata = $urandom;
        for (int cyc = 0; cyc < 300 && nresp < ops; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                exp_d = 32'h0; exp_e = 1'b0;
                if (q_rdata.size() > 0) begin exp_d = q_rdata.pop_front(); exp_e = q_err.pop_front(); end
                checks++; if (prev_resp) begin errors++; $display("FAIL b2b_double_pulse: got 2 consecutive cycles expected 1"); end
                checks++; if (resp_rdata !== exp_d || resp_error !== exp_e) begin errors++; $display("FAIL b2b_resp[%0d]: got rdata=%h err=%b expected rdata=%h err=%b", nresp, resp_rdata, resp_error, exp_d, exp_e); end
                nresp++;
            end
            prev_resp = resp_valid;
            if (req_ready) begin
                checks++; if (mem_read || mem_write || resp_valid) begin errors++; $display("FAIL b2b_ready_outside_idle: got ready=1 with rd=%b wr=%b resp=%b expected all 0", mem_read, mem_write, resp_valid); end
            end
            acc = req_valid && req_ready;
            if (acc) begin
                model(req_write, req_size, req_unsigned, req_addr, req_wdata, x_rdata, x_err, x_lat, x_rd, x_wr);
                q_rdata.push_back(x_rdata); q_err.push_back(x_err);
                if (sent > 0) begin
                    checks++; if (cyc - last_acc != prev_lat + 1) begin errors++; $display("FAIL b2b_accept_spacing[%0d]: got %0d expected %0d", sent, cyc - last_acc, prev_lat + 1); end
                end
                last_acc = cyc; prev_lat = x_lat; sent++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (sent < ops) begin
                    req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
                    req_unsigned = 1'($urandom_range(0, 1)); req_addr = 32'h100 + $urandom_range(0, 63);
                    req_wdata = $urandom;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (nresp != ops || sent != ops) begin errors++; $display("FAIL b2b_count: got sent=%0d resp=%0d expected %0d", sent, nresp, ops); end
        checks++; if (resp_cnt - r0 != ops) begin errors++; $display("FAIL b2b_pulse_cycles: got %0d expected %0d", resp_cnt - r0, ops); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_word_store_load();
        test_signed_byte_load();
        test_half_rmw();
        test_misaligned();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
